fnd_time_display: RTL and testbench

Parametrised multiplexed 7-segment display controller for DS1302 RTC data, successor to the fixed 4-digit HH:MM controller. Snapshots BCD register bytes on each RTC read-complete pulse, scans DIGITS digits showing a mode-selected window of time/date fields, and handles blinking separators, 12/24 h hour decoding, leading-zero blanking, and no-data/invalid-BCD indication. Sits between `ds1302read` (data + `dataValid`) and the board anode/segment pins, driven by the shared 1 ms `tickGen` strobe.

---
 rtl/fnd_pkg.sv | 42 ++++
 rtl/bcd7seg.sv | 18 +
 rtl/fnd_time_display.sv | 169 ++++++++++++++++
 tb/tb_fnd_time_display.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 7-segment time/date display.
// Segment patterns are active-low {g,f,e,d,c,b,a}; fields index the shadow bytes.
package fnd_pkg;

    localparam int unsigned NUM_FIELDS = 6;
    localparam int unsigned SEG_W      = 7;

    localparam logic [2:0] F_HRS  = 3'd0;
    localparam logic [2:0] F_MIN  = 3'd1;
    localparam logic [2:0] F_SEC  = 3'd2;
    localparam logic [2:0] F_MON  = 3'd3;
    localparam logic [2:0] F_DATE = 3'd4;
    localparam logic [2:0] F_YR   = 3'd5;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;

    localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Decoded DS1302 hours register.
    typedef struct packed {
        logic       is_12h;
        logic       pm;
        logic [3:0] tens;
        logic [3:0] ones;
    } hrs_t;

    // 12 h mode keeps only bit4 as tens and bit5 as PM; 24 h mode uses bits[5:4].
    function automatic hrs_t hrs_mask(input logic [7:0] b);
        hrs_t h;
        h.is_12h = b[7];
        h.pm     = b[7] & b[5];
        h.tens   = b[7] ? {3'b000, b[4]} : {2'b00, b[5:4]};
        h.ones   = b[3:0];
        return h;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// Nibble to active-low 7-segment glyph; non-decimal nibbles show 'E'.
//   nibble  : 4-bit value
//   glyph_c : {g,f,e,d,c,b,a}, combinational
module bcd7seg
    import fnd_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] glyph_c
);

    always_comb begin
        glyph_c = SEG_E;
        if (nibble <= 4'd9) begin
            glyph_c = SEG_DIGIT[nibble];
        end
    end

endmodule

// File: rtl/fnd_time_display.sv
// Multiplexed 7-segment display of DS1302 time/date fields.
//   clk, rst        : clock, synchronous active-high reset
//   tick            : scan strobe, advances one digit per pulse
//   valid           : snapshot strobe for the six RTC register bytes
//   *Data           : raw DS1302 bytes (sec, min, hrs, date, mon, yr)
//   mode            : field shown in the leftmost digit pair
//   an, seg, dp     : registered active-low anodes, segments, decimal point
module fnd_time_display
    import fnd_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned BLINK_TICKS = 500,
    parameter bit          LZB         = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              valid,
    input  logic [7:0]        secData,
    input  logic [7:0]        minData,
    input  logic [7:0]        hrsData,
    input  logic [7:0]        dateData,
    input  logic [7:0]        monData,
    input  logic [7:0]        yrData,
    input  logic [2:0]        mode,
    output logic [DIGITS-1:0] an,
    output logic [SEG_W-1:0]  seg,
    output logic              dp
);

    localparam int unsigned CW = $clog2(DIGITS);
    localparam int unsigned BW = $clog2(BLINK_TICKS) + 1;
    localparam int unsigned NP = DIGITS / 2;

    logic [7:0]        shadow_q [NUM_FIELDS];
    logic [7:0]        shadow_d [NUM_FIELDS];
    logic              has_data_q, has_data_d;
    logic [CW-1:0]     dig_q, dig_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_on_q, blink_on_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              dp_q, dp_d;

    logic [CW-1:0]     dig_next_c;
    logic [CW-1:0]     pair_c;
    logic [2:0]        mode_eff_c;
    logic [3:0]        fld_sum_c;
    logic [2:0]        fld_c;
    logic [7:0]        byte_c;
    logic [3:0]        tens_c;
    logic [3:0]        nibble_c;
    logic [SEG_W-1:0]  glyph_c;
    logic              hrs_shown_c;
    logic              dp_lit_c;
    hrs_t              hrs_c;

    bcd7seg u_bcd7seg (
        .nibble  (nibble_c),
        .glyph_c (glyph_c)
    );

    // Digit selection for the position the scan moves to on this tick.
    always_comb begin
        dig_next_c = (dig_q == CW'(DIGITS - 1)) ? '0 : dig_q + CW'(1);
        pair_c     = CW'((CW'(DIGITS - 1) - dig_next_c) >> 1);
        mode_eff_c = (mode >= 3'd6) ? 3'd0 : mode;
        fld_sum_c  = 4'(mode_eff_c) + 4'(pair_c);
        if (fld_sum_c >= 4'd6) begin
            fld_sum_c = fld_sum_c - 4'd6;
        end
        fld_c  = 3'(fld_sum_c);
        byte_c = shadow_q[fld_c];
        hrs_c  = hrs_mask(shadow_q[F_HRS]);

        if (fld_c == F_HRS) begin
            tens_c = hrs_c.tens;
        end else if (fld_c == F_SEC) begin
            tens_c = {1'b0, byte_c[6:4]};   // CH flag is not part of the value
        end else begin
            tens_c = byte_c[7:4];
        end
        nibble_c = dig_next_c[0] ? tens_c : byte_c[3:0];

        // Hours appear in some pair when the window wraps past the field list end.
        hrs_shown_c = (mode_eff_c == 3'd0) || ((4'(mode_eff_c) + 4'(NP)) > 4'd6);

        dp_lit_c = has_data_q &&
                   ((!dig_next_c[0] && (dig_next_c >= CW'(2)) && blink_on_q) ||
                    ((dig_next_c == '0) && hrs_shown_c && hrs_c.is_12h && hrs_c.pm));
    end

    // Next-state logic for snapshot, scan, blink and output registers.
    always_comb begin
        shadow_d    = shadow_q;
        has_data_d  = has_data_q;
        dig_d       = dig_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;

        if (valid) begin
            shadow_d[F_HRS]  = hrsData;
            shadow_d[F_MIN]  = minData;
            shadow_d[F_SEC]  = secData;
            shadow_d[F_MON]  = monData;
            shadow_d[F_DATE] = dateData;
            shadow_d[F_YR]   = yrData;
            has_data_d       = 1'b1;
        end

        // Snapshot re-phases the blink so the separator follows the RTC second.
        if (valid) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        if (tick) begin
            dig_d = dig_next_c;
            an_d  = ~(DIGITS'(1) << dig_next_c);
            if (!has_data_q) begin
                seg_d = SEG_DASH;
            end else if (LZB && (fld_c == F_HRS) && dig_next_c[0] && (tens_c == 4'd0)) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = glyph_c;
            end
            dp_d = ~dp_lit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_FIELDS); i++) begin
                shadow_q[i] <= '0;
            end
            has_data_q  <= 1'b0;
            dig_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            shadow_q    <= shadow_d;
            has_data_q  <= has_data_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_fnd_time_display.sv
// Randomised plus directed bench for fnd_time_display, two instances
// (4 digits / blink 500 / LZB on, 8 digits / blink 7 / LZB off) against a
// field-level reference model.
module tb_fnd_time_display;

    localparam int BT4 = 500;
    localparam int BT8 = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] sec_i = '0, min_i = '0, hrs_i = '0, date_i = '0, mon_i = '0, yr_i = '0;
    logic [2:0] mode = '0;

    logic [3:0] an4;
    logic [6:0] seg4;
    logic       dp4;
    logic [7:0] an8;
    logic [6:0] seg8;
    logic       dp8;

    always #5 clk = ~clk;

    fnd_time_display #(.DIGITS(4), .BLINK_TICKS(BT4), .LZB(1'b1)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .valid(valid),
        .secData(sec_i), .minData(min_i), .hrsData(hrs_i),
        .dateData(date_i), .monData(mon_i), .yrData(yr_i),
        .mode(mode), .an(an4), .seg(seg4), .dp(dp4)
    );

    fnd_time_display #(.DIGITS(8), .BLINK_TICKS(BT8), .LZB(1'b0)) dut8 (
        .clk(clk), .rst(rst), .tick(tick), .valid(valid),
        .secData(sec_i), .minData(min_i), .hrsData(hrs_i),
        .dateData(date_i), .monData(mon_i), .yrData(yr_i),
        .mode(mode), .an(an8), .seg(seg8), .dp(dp8)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: field bytes indexed hrs,min,sec,mon,date,yr.
    int   sh [6];
    bit   has;
    int   pos4, pos8, nt4, nt8;
    logic [7:0] e_an4, e_an8;
    logic [6:0] e_seg4, e_seg8;
    logic       e_dp4, e_dp8;

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    task automatic model_digit(input int nd, input int d, input int m, input bit lzb,
                               input bit phase_on, output logic [7:0] an,
                               output logic [6:0] sg, output logic dpo);
        int mm, p, f, b, tens, ones, nib;
        bit lit, shown, pm;
        an = 8'hFF;
        an[d] = 1'b0;
        sg = 7'b0111111;
        dpo = 1'b1;
        if (has) begin
            mm = (m >= 6) ? 0 : m;
            p = (nd - 1 - d) / 2;
            f = (mm + p) % 6;
            b = sh[f];
            ones = b % 16;
            if (f == 2)      tens = (b / 16) % 8;
            else if (f == 0) tens = (b >= 128) ? ((b / 16) % 2) : ((b / 16) % 4);
            else             tens = b / 16;
            nib = (d % 2 == 1) ? tens : ones;
            sg = glyph(nib);
            if (f == 0 && d % 2 == 1 && lzb && tens == 0) sg = 7'b1111111;
            shown = 1'b0;
            for (int q = 0; q < nd / 2; q++) if ((mm + q) % 6 == 0) shown = 1'b1;
            pm = (sh[0] >= 128) && ((sh[0] / 32) % 2 == 1);
            lit = (d % 2 == 0) && (d >= 2) && phase_on;
            if (d == 0 && shown && pm) lit = 1'b1;
            dpo = ~lit;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) sh[i] = 0;
        has = 1'b0;
        pos4 = 0; pos8 = 0; nt4 = 0; nt8 = 0;
        e_an4 = 8'hFF; e_an8 = 8'hFF;
        e_seg4 = 7'h7F; e_seg8 = 7'h7F;
        e_dp4 = 1'b1; e_dp8 = 1'b1;
    endtask

    // One clock: drive at negedge, advance model, compare after the edge.
    task automatic step(input bit t, input bit v, input bit r);
        @(negedge clk);
        tick = t; valid = v; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (t) begin
                pos4 = (pos4 + 1) % 4;
                pos8 = (pos8 + 1) % 8;
                model_digit(4, pos4, int'(mode), 1'b1, ((nt4 / BT4) % 2) == 0, e_an4, e_seg4, e_dp4);
                model_digit(8, pos8, int'(mode), 1'b0, ((nt8 / BT8) % 2) == 0, e_an8, e_seg8, e_dp8);
                nt4++; nt8++;
            end
            if (v) begin
                sh[0] = int'(hrs_i); sh[1] = int'(min_i); sh[2] = int'(sec_i);
                sh[3] = int'(mon_i); sh[4] = int'(date_i); sh[5] = int'(yr_i);
                has = 1'b1;
                nt4 = 0; nt8 = 0;
            end
        end
        check("an4", 32'(an4), 32'(e_an4[3:0]));
        check("seg4", 32'(seg4), 32'(e_seg4));
        check("dp4", 32'(dp4), 32'(e_dp4));
        check("an8", 32'(an8), 32'(e_an8));
        check("seg8", 32'(seg8), 32'(e_seg8));
        check("dp8", 32'(dp8), 32'(e_dp8));
        tick = 1'b0; valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                        input logic [7:0] mo, input logic [7:0] dt, input logic [7:0] y);
        hrs_i = h; min_i = mi; sec_i = s; mon_i = mo; date_i = dt; yr_i = y;
        step(1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [7:0] rand_bcd(input int maxv);
        int v;
        v = int'($urandom_range(0, maxv));
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        model_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // No data yet: dashes, scan starts at digit 1.
        ticks(4);

        mode = 3'd0;
        load(8'h09, 8'h45, 8'h00, 8'h01, 8'h01, 8'h00);
        ticks(1002);

        load(8'hB1, 8'h07, 8'h00, 8'h01, 8'h01, 8'h00);
        ticks(8);

        mode = 3'd4;
        load(8'h23, 8'h59, 8'h10, 8'h12, 8'h31, 8'h25);
        ticks(8);

        mode = 3'd1;
        load(8'h12, 8'h4C, 8'hA7, 8'h12, 8'h31, 8'h25);
        ticks(8);

        // Snapshot coincident with a tick.
        hrs_i = 8'h18; min_i = 8'h30; sec_i = 8'h05;
        step(1'b1, 1'b1, 1'b0);
        ticks(10);

        mode = 3'd7;
        ticks(8);

        // Reset mid-scan.
        ticks(2);
        step(1'b0, 1'b0, 1'b1);
        ticks(3);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    hrs_i = 8'($urandom); min_i = 8'($urandom); sec_i = 8'($urandom);
                    mon_i = 8'($urandom); date_i = 8'($urandom); yr_i = 8'($urandom);
                end else begin
                    if ($urandom_range(0, 1) == 0) hrs_i = rand_bcd(23);
                    else hrs_i = 8'h80 | 8'(($urandom_range(0, 1)) << 5) | rand_bcd(12);
                    min_i = rand_bcd(59); sec_i = rand_bcd(59) | 8'(($urandom_range(0, 1)) << 7);
                    mon_i = rand_bcd(12); date_i = rand_bcd(31); yr_i = rand_bcd(99);
                end
                step($urandom_range(0, 2) == 0, 1'b1, 1'b0);
            end else begin
                step($urandom_range(0, 2) == 0, 1'b0, $urandom_range(0, 1999) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
